fifo_rd_serializer: RTL
=======================

# fifo_rd_serializer

Reader-side adapter for the team's synchronous show-ahead FIFOs. It pops IN_WIDTH-bit words from a FIFO read port and streams them out as IN_WIDTH/OUT_WIDTH narrower beats on a valid/ready master interface, least-significant slice first. It sits between a wide FIFO and a narrow consumer such as a byte-wide peripheral, and sustains one beat per cycle across word boundaries.

## Interface
- IN_WIDTH, default 32: FIFO word width.
- OUT_WIDTH, default 8: output beat width. IN_WIDTH % OUT_WIDTH == 0 is required; it is checked by an elaboration assertion.
- RATIO (localparam) = IN_WIDTH/OUT_WIDTH. The beat counter is $clog2(RATIO>1?RATIO:2) bits wide.
- clk  in  1  clock.
- arst  in  1  reset, asynchronous, active-high.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_data_i  in  IN_WIDTH  FIFO head word. It is combinational show-ahead and valid whenever fifo_empty_i=0.
- fifo_read_o  out  1  pop strobe. The FIFO advances its read pointer on the next clk edge.
- m_valid_o  out  1  output beat valid.
- m_ready_i  in  1  consumer accepts the beat.
- m_data_o  out  OUT_WIDTH  output beat.
- m_last_o  out  1  final beat of the current word.
- busy_o  out  1  a word is held (state SERIAL).

## Operation
- Storage: word register word_ff [IN_WIDTH], beat counter beat_ff, state register.
- States:
  - IDLE: no word held.
  - SERIAL: word held, beat beat_ff presented.
- Handshake: a beat is accepted when m_valid_o && m_ready_i ("fire").
- fire_last = fire && beat_ff == RATIO-1.
- Load condition: load = ~fifo_empty_i && (state==IDLE || fire_last).
  - fifo_read_o = load && ~arst.
  - fifo_read_o is never asserted while fifo_empty_i=1, so the FIFO error flag is never triggered.
- On load: word_ff <= fifo_data_i, beat_ff <= 0, state <= SERIAL.
- On fire without fire_last: beat_ff <= beat_ff+1. word_ff is unchanged.
- On fire_last with FIFO empty: state <= IDLE, beat_ff <= 0.
- Outputs:
  - m_valid_o = (state==SERIAL).
  - m_data_o = word_ff[beat_ff*OUT_WIDTH +: OUT_WIDTH] in SERIAL, otherwise 0.
  - m_last_o = m_valid_o && beat_ff==RATIO-1.
  - busy_o = (state==SERIAL).
- AXI-stream stability: while m_valid_o && ~m_ready_i, m_data_o, m_last_o and beat_ff hold. No pop occurs.
- RATIO==1: every beat is last. This degenerates to a one-register-stage FIFO-to-stream bridge with full throughput.
- m_valid_o never depends combinationally on m_ready_i. fifo_read_o does depend combinationally on m_ready_i (via fire_last) and on fifo_empty_i.

## Timing
- Reset values:
  - state IDLE, beat_ff 0, word_ff 0.
  - m_valid_o 0, m_data_o 0, m_last_o 0, busy_o 0.
  - fifo_read_o is forced 0 while arst is high.
- Reset mid-word: outputs drop to 0 asynchronously and the remaining beats are discarded. After release, the next FIFO word starts at beat 0.
- Latency: fifo_empty_i falls in cycle N (IDLE), fifo_read_o is high in cycle N, and the first beat is valid in cycle N+1.
- Throughput: with m_ready_i held at 1 and the FIFO non-empty, output is RATIO beats per word with zero bubbles between words.
  - The next word is popped in the same cycle as the last-beat handshake.
- FIFO empty at the last-beat handshake: m_valid_o is 0 the next cycle (IDLE). A later word follows the IDLE latency rule.
- Exactly one fifo_read_o pulse (one cycle) occurs per word consumed.
- beat_ff wraps only via load or a return to IDLE. It never increments past RATIO-1.

## Test plan
- Reset: assert arst with fifo_empty_i=0 → fifo_read_o=0, m_valid_o=0, m_data_o=0, busy_o=0. After release, the first pop occurs in the first cycle.
- Single word, IN=32/OUT=8: FIFO holds 0xDDCCBBAA, m_ready_i=1 → one fifo_read_o pulse, then beats AA, BB, CC, DD on 4 consecutive cycles, m_last_o only on DD, then m_valid_o=0.
- Back-to-back words: FIFO holds 0x44332211 and 0x88776655, m_ready_i=1 → 8 consecutive beats 11..88 with no gap. The second fifo_read_o pulse coincides with the handshake of beat 44.
- Backpressure: m_ready_i=0 for 3 cycles while beat BB is presented → m_data_o stays BB and m_last_o stays 0 for those cycles, no fifo_read_o, CC follows the cycle after ready returns.
- Underflow guard: fifo_empty_i=1 for 20 cycles, including the cycle of a last-beat handshake → fifo_read_o=0 throughout and m_valid_o=0 after the last beat.
- Reset mid-word: arst pulse after beat BB of 0xDDCCBBAA, with next FIFO word 0x0000EE99 → CC and DD are never emitted, and the output restarts with 99, EE, 00, 00.

Source files
------------

// File: rtl/fifo_rd_serializer.sv
// Pops IN_WIDTH-bit words from a show-ahead FIFO and streams them out as
// OUT_WIDTH-bit valid/ready beats, least-significant slice first.
module fifo_rd_serializer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 fifo_empty_i,
    input  logic [IN_WIDTH-1:0]  fifo_data_i,
    output logic                 fifo_read_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [OUT_WIDTH-1:0] m_data_o,
    output logic                 m_last_o,
    output logic                 busy_o
);

    localparam int RATIO  = IN_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = $clog2(RATIO > 1 ? RATIO : 2);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    generate
        if (OUT_WIDTH < 1 || IN_WIDTH < OUT_WIDTH || (IN_WIDTH % OUT_WIDTH) != 0) begin : g_width_check
            $error("fifo_rd_serializer: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE   = 1'b0,
        SERIAL = 1'b1
    } state_t;

    state_t                state_ff, state_nxt;
    logic [BEAT_W-1:0]     beat_ff,  beat_nxt;
    logic [IN_WIDTH-1:0]   word_ff,  word_nxt;

    logic fire;
    logic fire_last;
    logic load;

    assign fire      = m_valid_o && m_ready_i;
    assign fire_last = fire && (beat_ff == LAST_BEAT);
    // Refill in the same cycle as the last handshake so words stream with no bubble.
    assign load      = !fifo_empty_i && ((state_ff == IDLE) || fire_last);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_ff <= IDLE;
            beat_ff  <= '0;
            // NOTE: the word register is reset too, so m_data_o and any debug view of it are clean after reset.
            word_ff  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_ff <= state_nxt;
            beat_ff  <= beat_nxt;
            word_ff  <= word_nxt;
        end
    end

    always_comb begin
        // NOTE: hold-by-default assignments first, so no branch leaves a variable unassigned (no latch).
        state_nxt = state_ff;
        beat_nxt  = beat_ff;
        word_nxt  = word_ff;
        if (load) begin
            word_nxt  = fifo_data_i;
            beat_nxt  = '0;
            state_nxt = SERIAL;
        end else if (fire_last) begin
            beat_nxt  = '0;
            state_nxt = IDLE;
        end else if (fire) begin
            beat_nxt  = beat_ff + BEAT_W'(1);
        end
    end

    assign m_valid_o   = (state_ff == SERIAL);
    assign busy_o      = (state_ff == SERIAL);
    assign m_last_o    = m_valid_o && (beat_ff == LAST_BEAT);
    assign m_data_o    = m_valid_o ? word_ff[int'(beat_ff) * OUT_WIDTH +: OUT_WIDTH] : '0;
    // Gated by arst so the FIFO pointer cannot move while this block is held in reset.
    assign fifo_read_o = load && !arst;

endmodule
